// File: rtl/freq_bcd_display.sv
// NCO frequency readout: freq = (sample_freq * phase_inc) >> ACC_WIDTH, converted to BCD
// by a serial double-dabble engine and shown on active-low seven-segment digits.
`timescale 1ns/1ps
module freq_bcd_display #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned FREQ_WIDTH = 18,
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned AUTO       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [FREQ_WIDTH-1:0]   sample_freq,
    input  logic [ACC_WIDTH-1:0]    phase_inc,
    input  logic                    start,
    input  logic                    blank_lz,
    output logic [7*DIGITS-1:0]     seg,
    output logic [4*DIGITS-1:0]     bcd,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic                    overflow
);

    // Decimal digits of 2^w-1 plus one spare digit of headroom.
    function automatic int unsigned bcd_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        return n + 1;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < 20; i++) begin
            if (i < int'(n)) p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    localparam int unsigned PROD_W    = FREQ_WIDTH + ACC_WIDTH;
    localparam int unsigned CONV_DIG  = bcd_digits(FREQ_WIDTH);
    localparam int unsigned ACC_DIG   = (CONV_DIG > DIGITS) ? CONV_DIG : DIGITS;
    localparam int unsigned BCD_W     = 4 * ACC_DIG;
    localparam int unsigned CNT_W     = $clog2(FREQ_WIDTH);
    localparam logic [63:0] MAX_DISP  = 64'(pow10(DIGITS) - 64'd1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_CONV, S_LOAD} state_t;

    state_t                  state_q, state_d;
    logic [FREQ_WIDTH-1:0]   sf_q, sf_d;
    logic [ACC_WIDTH-1:0]    pi_q, pi_d;
    logic [FREQ_WIDTH-1:0]   bin_q, bin_d;
    logic [FREQ_WIDTH-1:0]   freq_q, freq_d;
    logic [BCD_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*DIGITS-1:0]     bcd_q, bcd_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;

    logic [PROD_W-1:0]       product_c;
    logic [FREQ_WIDTH-1:0]   freq_c;
    logic [BCD_W-1:0]        acc_adj_c;
    logic                    trigger_c;

    assign product_c = PROD_W'(sf_q) * PROD_W'(pi_q);
    assign freq_c    = FREQ_WIDTH'(product_c >> ACC_WIDTH);
    assign trigger_c = start || ((AUTO != 0) && ((sample_freq != sf_q) || (phase_inc != pi_q)));

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        acc_adj_c = acc_q;
        for (int i = 0; i < int'(ACC_DIG); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sf_q    <= '0;
            pi_q    <= '0;
            bin_q   <= '0;
            freq_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sf_q    <= sf_d;
            pi_q    <= pi_d;
            bin_q   <= bin_d;
            freq_q  <= freq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sf_d    = sf_q;
        pi_d    = pi_q;
        bin_d   = bin_q;
        freq_d  = freq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (trigger_c) begin
                    sf_d    = sample_freq;
                    pi_d    = phase_inc;
                    busy_d  = 1'b1;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                bin_d   = freq_c;
                freq_d  = freq_c;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                acc_d = {acc_adj_c[BCD_W-2:0], bin_q[FREQ_WIDTH-1]};
                bin_d = {bin_q[FREQ_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FREQ_WIDTH - 1)) state_d = S_LOAD;
            end
            S_LOAD: begin
                ovf_d   = 64'(freq_q) > MAX_DISP;
                bcd_d   = acc_q[4*DIGITS-1:0];
                valid_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Display decode; blanking follows blank_lz live without reconversion.
    logic       lz_c;
    logic [3:0] digit_c;
    always_comb begin
        seg     = '1;
        lz_c    = 1'b1;
        digit_c = 4'd0;
        if (valid_q) begin
            for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
                digit_c = bcd_q[4*k +: 4];
                lz_c    = lz_c && (digit_c == 4'd0);
                if (ovf_q)                           seg[7*k +: 7] = SEG_DASH;
                else if (blank_lz && lz_c && k != 0) seg[7*k +: 7] = SEG_BLANK;
                else                                 seg[7*k +: 7] = seg7(digit_c);
            end
        end
    end

    assign bcd      = bcd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_freq_bcd_display.sv
// Scoreboard bench for freq_bcd_display: a manual-start 6-digit instance and an
// auto-start 5-digit instance, each checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_freq_bcd_display;

    localparam int unsigned AW = 32;
    localparam int unsigned FW = 18;
    localparam int unsigned DA = 6;
    localparam int unsigned DB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, rst_b, start_a, start_b, blz_a, blz_b;
    logic [FW-1:0]   sf_a, sf_b;
    logic [AW-1:0]   pi_a, pi_b;
    logic [7*DA-1:0] seg_a;
    logic [4*DA-1:0] bcd_a;
    logic [7*DB-1:0] seg_b;
    logic [4*DB-1:0] bcd_b;
    logic            busy_a, done_a, valid_a, ovf_a;
    logic            busy_b, done_b, valid_b, ovf_b;

    freq_bcd_display #(.ACC_WIDTH(AW), .FREQ_WIDTH(FW), .DIGITS(DA), .AUTO(0)) u_dut_a (
        .clk(clk), .reset(rst_a), .sample_freq(sf_a), .phase_inc(pi_a),
        .start(start_a), .blank_lz(blz_a), .seg(seg_a), .bcd(bcd_a),
        .busy(busy_a), .done(done_a), .valid(valid_a), .overflow(ovf_a));

    freq_bcd_display #(.ACC_WIDTH(AW), .FREQ_WIDTH(FW), .DIGITS(DB), .AUTO(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .sample_freq(sf_b), .phase_inc(pi_b),
        .start(start_b), .blank_lz(blz_b), .seg(seg_b), .bcd(bcd_b),
        .busy(busy_b), .done(done_b), .valid(valid_b), .overflow(ovf_b));

    int unsigned     nchk = 0;
    int unsigned     npass = 0;
    longint unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 64'd1;

    typedef struct {
        logic [63:0]     bcd;
        logic            ovf;
        logic [62:0]     seg;
        longint unsigned cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb, et;

    function automatic longint unsigned p10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Reference: plain arithmetic on the frequency value, no bit-serial steps.
    function automatic exp_t model(input logic [FW-1:0] sf, input logic [AW-1:0] pi,
                                   input int nd, input logic blz, input longint unsigned when);
        exp_t            e;
        longint unsigned f, shown;
        int              dig;
        f     = (64'(sf) * 64'(pi)) >> AW;
        shown = f % p10(nd);
        e.ovf = f > (p10(nd) - 64'd1);
        e.bcd = 64'd0;
        e.seg = 63'd0;
        e.cyc = when;
        for (int k = 0; k < nd; k++) begin
            dig   = int'((shown / p10(k)) % 64'd10);
            e.bcd = e.bcd | (64'(dig) << (4 * k));
            if (e.ovf)                               e.seg[7*k +: 7] = 7'b0111111;
            else if (blz && k > 0 && shown < p10(k)) e.seg[7*k +: 7] = 7'b1111111;
            else                                     e.seg[7*k +: 7] = seg_of(dig);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitors: every done pulse is matched against the head of its queue.
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_done_a: got done at cycle %0d expected none", cyc);
            end else begin
                ea = q_a.pop_front();
                check("done_cycle_a", 64'(cyc), 64'(ea.cyc));
                check("bcd_a", 64'(bcd_a), ea.bcd);
                check("overflow_a", 64'(ovf_a), 64'(ea.ovf));
                check("seg_a", 64'(seg_a), 64'(ea.seg));
                check("valid_a", 64'(valid_a), 64'd1);
                check("busy_clear_a", 64'(busy_a), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_done_b: got done at cycle %0d expected none", cyc);
            end else begin
                eb = q_b.pop_front();
                check("done_cycle_b", 64'(cyc), 64'(eb.cyc));
                check("bcd_b", 64'(bcd_b), eb.bcd);
                check("overflow_b", 64'(ovf_b), 64'(eb.ovf));
                check("seg_b", 64'(seg_b), 64'(eb.seg));
                check("valid_b", 64'(valid_b), 64'd1);
            end
        end
    end

    task automatic issue_a(input logic [FW-1:0] sf, input logic [AW-1:0] pi, input logic blz);
        @(negedge clk);
        sf_a    = sf;
        pi_a    = pi;
        blz_a   = blz;
        start_a = 1'b1;
        q_a.push_back(model(sf, pi, DA, blz, cyc + 64'(FW + 3)));
        @(negedge clk);
        start_a = 1'b0;
        check("busy_set_a", 64'(busy_a), 64'd1);
        repeat (FW + 3) @(negedge clk);
    endtask

    task automatic set_b(input logic [FW-1:0] sf, input logic [AW-1:0] pi, input logic blz);
        logic [AW-1:0] p;
        p = pi;
        if (sf == sf_b && p == pi_b) p = p ^ 32'd1;
        @(negedge clk);
        sf_b  = sf;
        pi_b  = p;
        blz_b = blz;
        q_b.push_back(model(sf, p, DB, blz, cyc + 64'(FW + 3)));
        repeat (FW + 5) @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_seg"}, 64'(seg_a), (64'd1 << (7 * DA)) - 64'd1);
        check({tag, "_bcd"}, 64'(bcd_a), 64'd0);
        check({tag, "_busy"}, 64'(busy_a), 64'd0);
        check({tag, "_done"}, 64'(done_a), 64'd0);
        check({tag, "_valid"}, 64'(valid_a), 64'd0);
        check({tag, "_ovf"}, 64'(ovf_a), 64'd0);
    endtask

    longint unsigned n0;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        blz_a = 1'b0; blz_b = 1'b0;
        sf_a = '0; pi_a = '0; sf_b = '0; pi_b = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check_reset_a("reset_a");
        check("reset_b_seg", 64'(seg_b), (64'd1 << (7 * DB)) - 64'd1);
        repeat (3) @(negedge clk);
        check("reset_b_idle", 64'(busy_b), 64'd0);

        // Manual-start instance: directed cases then random
        issue_a(18'd5000, 32'd429496730, 1'b0);
        @(negedge clk);
        blz_a = 1'b1;
        @(negedge clk);
        et = model(18'd5000, 32'd429496730, DA, 1'b1, 64'd0);
        check("blank_lz_live", 64'(seg_a), 64'(et.seg));
        issue_a(18'd5000, 32'd0, 1'b1);
        issue_a(18'd262143, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 14; i++) begin
            issue_a(FW'($urandom_range(0, 262143)), $urandom, 1'($urandom_range(0, 1)));
        end

        // start held high: exactly two back-to-back conversions
        @(negedge clk);
        blz_a = 1'b0;
        sf_a  = 18'd12345;
        pi_a  = $urandom;
        n0    = cyc;
        q_a.push_back(model(sf_a, pi_a, DA, 1'b0, n0 + 64'd21));
        q_a.push_back(model(sf_a, pi_a, DA, 1'b0, n0 + 64'd42));
        start_a = 1'b1;
        repeat (40) @(negedge clk);
        start_a = 1'b0;
        repeat (10) @(negedge clk);

        // reset 10 cycles into a conversion discards it
        sf_a = 18'd777; pi_a = 32'h8000_0000;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_reset_a("mid_reset");
        repeat (30) @(negedge clk);

        // reset and start together: start is lost
        start_a = 1'b1; rst_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; rst_a = 1'b0;
        check("reset_start_busy", 64'(busy_a), 64'd0);
        repeat (25) @(negedge clk);
        issue_a(18'd100, 32'h4000_0000, 1'b1);

        // Auto-start 5-digit instance
        set_b(18'd200000, 32'hFFFF_FFFF, 1'b0);
        set_b(18'd50000, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        n0   = cyc;
        sf_b = 18'd99999;
        pi_b = 32'h2000_0000;
        q_b.push_back(model(sf_b, pi_b, DB, blz_b, n0 + 64'd21));
        repeat (8) @(negedge clk);
        pi_b = 32'hC000_0000;
        q_b.push_back(model(sf_b, pi_b, DB, blz_b, n0 + 64'd42));
        repeat (45) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_b(FW'($urandom_range(0, 262143)), $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_a_drained", 64'(q_a.size()), 64'd0);
        check("queue_b_drained", 64'(q_b.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
